lite_reg_router: RTL

Sits between the Xillybus Lite user register bus (user_addr/user_wren/user_rden/user_wstrb/user_wr_data/user_rd_data/user_irq) and up to N_CLIENTS user register banks.
- Decodes a 4-bit region field, steers write/read strobes to one client and aligns the returned read data.
- Owns a small control register block holding the ID, interrupt pending/mask and an unmapped-access counter.
- Aggregates the client interrupt lines into the single user_irq.

---
 rtl/lite_router_pkg.sv | 30 +++
 rtl/lite_irq_ctrl.sv | 63 ++++++
 rtl/lite_reg_router.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lite_router_pkg.sv
// Shared address-map constants and read-source encoding for the Xillybus Lite
// register router.
package lite_router_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REGION_MSB = 15;
   localparam int unsigned REGION_LSB = 12;
   localparam int unsigned REGION_W   = REGION_MSB - REGION_LSB + 1;
   localparam int unsigned OFFSET_W   = 12;

   localparam logic [OFFSET_W-1:0] OFF_ID           = 12'h000;
   localparam logic [OFFSET_W-1:0] OFF_IRQ_PENDING  = 12'h004;
   localparam logic [OFFSET_W-1:0] OFF_IRQ_MASK     = 12'h008;
   localparam logic [OFFSET_W-1:0] OFF_IRQ_FORCE    = 12'h00C;
   localparam logic [OFFSET_W-1:0] OFF_UNMAPPED_CNT = 12'h010;

   // Control registers decode on the word index; the byte-offset bits are ignored.
   localparam logic [OFFSET_W-3:0] WORD_ID           = OFF_ID[OFFSET_W-1:2];
   localparam logic [OFFSET_W-3:0] WORD_IRQ_PENDING  = OFF_IRQ_PENDING[OFFSET_W-1:2];
   localparam logic [OFFSET_W-3:0] WORD_IRQ_MASK     = OFF_IRQ_MASK[OFFSET_W-1:2];
   localparam logic [OFFSET_W-3:0] WORD_IRQ_FORCE    = OFF_IRQ_FORCE[OFFSET_W-1:2];
   localparam logic [OFFSET_W-3:0] WORD_UNMAPPED_CNT = OFF_UNMAPPED_CNT[OFFSET_W-1:2];

   typedef enum logic [1:0] {
      SRC_CTRL     = 2'd0,
      SRC_CLIENT   = 2'd1,
      SRC_UNMAPPED = 2'd2
   } rd_src_e;

endpackage

// File: rtl/lite_irq_ctrl.sv
// Client interrupt edge detection, pending/mask/force registers and the
// registered aggregate interrupt.
module lite_irq_ctrl #(
   parameter int unsigned N_CLIENTS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CLIENTS-1:0] cli_irq,
   input  logic                 wr_pending,
   input  logic                 wr_mask,
   input  logic                 wr_force,
   input  logic [3:0]           wstrb,
   input  logic [31:0]          wr_data,
   output logic [N_CLIENTS-1:0] pending,
   output logic [N_CLIENTS-1:0] mask,
   output logic                 irq
);

   logic [N_CLIENTS-1:0] cli_irq_q;
   logic [N_CLIENTS-1:0] pending_q, pending_d;
   logic [N_CLIENTS-1:0] mask_q, mask_d;
   logic                 irq_q, irq_d;
   logic [N_CLIENTS-1:0] lane_c, wbits_c, set_c, clr_c;
   logic                 unused_c;

   assign unused_c = ^{wstrb, wr_data};

   always_comb begin
      lane_c = '0;
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
         lane_c[i] = wstrb[i/8];
      end
      wbits_c = wr_data[N_CLIENTS-1:0] & lane_c;
      set_c   = cli_irq & ~cli_irq_q;
      if (wr_force) begin
         set_c = set_c | wbits_c;
      end
      clr_c     = wr_pending ? wbits_c : '0;
      // Set is applied after clear so a same-cycle set always wins.
      pending_d = (pending_q & ~clr_c) | set_c;
      mask_d    = wr_mask ? ((mask_q & ~lane_c) | wbits_c) : mask_q;
      irq_d     = |(pending_q & mask_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cli_irq_q <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         cli_irq_q <= cli_irq;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         irq_q     <= irq_d;
      end
   end

   assign pending = pending_q;
   assign mask    = mask_q;
   assign irq     = irq_q;

endmodule

// File: rtl/lite_reg_router.sv
// Xillybus Lite user-bus router: region decode to client banks, 1-cycle read
// mux, control register block and interrupt aggregation.
module lite_reg_router
   import lite_router_pkg::*;
#(
   parameter int unsigned N_CLIENTS     = 4,
   parameter logic [31:0] ID_VALUE      = 32'h4C52_0001,
   parameter logic [31:0] UNMAPPED_DATA = 32'hBADA_DD00
) (
   input  logic                      bus_clk,
   input  logic                      bus_rst,
   input  logic [31:0]               user_addr,
   input  logic                      user_wren,
   input  logic [3:0]                user_wstrb,
   input  logic [31:0]               user_wr_data,
   input  logic                      user_rden,
   output logic [31:0]               user_rd_data,
   output logic                      user_irq,
   output logic [11:0]               cli_addr,
   output logic [31:0]               cli_wr_data,
   output logic [3:0]                cli_wstrb,
   output logic [N_CLIENTS-1:0]      cli_wren,
   output logic [N_CLIENTS-1:0]      cli_rden,
   input  logic [32*N_CLIENTS-1:0]   cli_rd_data,
   input  logic [N_CLIENTS-1:0]      cli_irq
);

   logic [REGION_W-1:0]   region_c;
   logic [OFFSET_W-1:0]   offset_c;
   logic [OFFSET_W-3:0]   word_c;
   logic                  is_ctrl_c, is_client_c, is_unmapped_c, ctrl_wr_c;
   logic [3:0]            cli_idx_c;
   logic [31:0]           ctrl_rd_c, cli_slice_c;
   logic [N_CLIENTS-1:0]  pending_c, mask_c;
   logic                  unused_c;

   rd_src_e     rd_src_q, rd_src_d;
   logic [3:0]  rd_idx_q, rd_idx_d;
   logic [31:0] rd_val_q, rd_val_d;
   logic [15:0] cnt_q, cnt_d;

   assign unused_c = ^user_addr[31:16];

   // Region decode and one-hot client strobes.
   always_comb begin
      region_c      = user_addr[REGION_MSB:REGION_LSB];
      offset_c      = user_addr[OFFSET_W-1:0];
      word_c        = offset_c[OFFSET_W-1:2];
      is_ctrl_c     = (region_c == 4'd0);
      is_client_c   = !is_ctrl_c && (32'(region_c) <= N_CLIENTS);
      is_unmapped_c = !is_ctrl_c && !is_client_c;
      ctrl_wr_c     = user_wren && is_ctrl_c;
      cli_idx_c     = region_c - 4'd1;
      cli_wren      = '0;
      cli_rden      = '0;
      for (int unsigned k = 0; k < N_CLIENTS; k++) begin
         cli_wren[k] = user_wren && (region_c == 4'(k + 1));
         cli_rden[k] = user_rden && !user_wren && (region_c == 4'(k + 1));
      end
   end

   assign cli_addr    = offset_c;
   assign cli_wr_data = user_wr_data;
   assign cli_wstrb   = user_wstrb;

   lite_irq_ctrl #(.N_CLIENTS(N_CLIENTS)) u_irq (
      .clk        (bus_clk),
      .rst        (bus_rst),
      .cli_irq    (cli_irq),
      .wr_pending (ctrl_wr_c && (word_c == WORD_IRQ_PENDING)),
      .wr_mask    (ctrl_wr_c && (word_c == WORD_IRQ_MASK)),
      .wr_force   (ctrl_wr_c && (word_c == WORD_IRQ_FORCE)),
      .wstrb      (user_wstrb),
      .wr_data    (user_wr_data),
      .pending    (pending_c),
      .mask       (mask_c),
      .irq        (user_irq)
   );

   always_comb begin
      ctrl_rd_c = '0;
      case (word_c)
         WORD_ID:           ctrl_rd_c = ID_VALUE;
         WORD_IRQ_PENDING:  ctrl_rd_c = 32'(pending_c);
         WORD_IRQ_MASK:     ctrl_rd_c = 32'(mask_c);
         WORD_UNMAPPED_CNT: ctrl_rd_c = 32'(cnt_q);
         default:           ctrl_rd_c = '0;
      endcase
   end

   always_comb begin
      cli_slice_c = '0;
      for (int unsigned k = 0; k < N_CLIENTS; k++) begin
         if (rd_idx_q == 4'(k)) begin
            cli_slice_c = cli_rd_data[k*32 +: 32];
         end
      end
   end

   // Read source/value; client data is live for one cycle, then parked in rd_val_q.
   always_comb begin
      rd_src_d = rd_src_q;
      rd_idx_d = rd_idx_q;
      rd_val_d = rd_val_q;
      if (rd_src_q == SRC_CLIENT) begin
         rd_src_d = SRC_CTRL;
         rd_val_d = cli_slice_c;
      end
      if (user_rden) begin
         if (user_wren || is_unmapped_c) begin
            rd_src_d = SRC_UNMAPPED;
            rd_val_d = UNMAPPED_DATA;
         end else if (is_ctrl_c) begin
            rd_src_d = SRC_CTRL;
            rd_val_d = ctrl_rd_c;
         end else begin
            rd_src_d = SRC_CLIENT;
            rd_idx_d = cli_idx_c;
         end
      end
   end

   assign user_rd_data = (rd_src_q == SRC_CLIENT) ? cli_slice_c : rd_val_q;

   always_comb begin
      cnt_d = cnt_q;
      if (ctrl_wr_c && (word_c == WORD_UNMAPPED_CNT)) begin
         cnt_d = '0;
      end else if ((user_wren || user_rden) && is_unmapped_c && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         rd_src_q <= SRC_CTRL;
         rd_idx_q <= '0;
         rd_val_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_src_q <= rd_src_d;
         rd_idx_q <= rd_idx_d;
         rd_val_q <= rd_val_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
